// File: rtl/mips_defs.sv
// Shared datapath widths, immediate-extension codes and ALU opcodes for the
// operand-fetch stage and the ALU it feeds.
package mips_defs;

    localparam int DW = 32;
    localparam int AW = 5;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SRA = 3'b101;

    // The reserved code 11 behaves like zero-extension.
    function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic [1:0] op);
        logic [31:0] r;
        case (op)
            EXT_SIGN: r = {{16{imm[15]}}, imm};
            EXT_LUI:  r = {imm, 16'h0000};
            default:  r = {16'h0000, imm};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/grf.sv
// General register file: 32 x DW, synchronous write, two combinational read
// ports. Register 0 is hard zero; a same-cycle write is bypassed to readers.
module grf #(
    parameter int DW = mips_defs::DW,
    parameter int AW = mips_defs::AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic [AW-1:0] ra0,
    input  logic [AW-1:0] ra1,
    output logic [DW-1:0] rd0,
    output logic [DW-1:0] rd1
);
    localparam int NREG = 1 << AW;

    logic [DW-1:0] regs [NREG];
    logic [AW-1:0] ra [2];
    logic [DW-1:0] rd [2];

    assign ra[0] = ra0;
    assign ra[1] = ra1;
    assign rd0   = rd[0];
    assign rd1   = rd[1];

    // Register 0 is only ever cleared, never written, so it always holds zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_read
            assign rd[gi] = (ra[gi] == '0)                   ? '0      :
                            (wb_en && (wb_addr == ra[gi]))   ? wb_data :
                                                               regs[ra[gi]];
        end
    endgenerate

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads the GRF, forms the immediate, and holds one
// instruction's A/B/ALUOp in an output register with valid/ready and flush.
module operand_fetch #(
    parameter int DW = mips_defs::DW,
    parameter int AW = mips_defs::AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    input  logic [15:0]   imm,
    input  logic [1:0]    ext_op,
    input  logic          b_sel,
    input  logic [2:0]    alu_op_in,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] A,
    output logic [DW-1:0] B,
    output logic [2:0]    ALUOp
);
    import mips_defs::*;

    logic          valid_reg;
    logic [DW-1:0] a_reg;
    logic [DW-1:0] b_reg;
    logic [2:0]    op_reg;

    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;
    logic [DW-1:0] ext_val;
    logic [DW-1:0] b_next;
    logic          load;

    grf #(.DW(DW), .AW(AW)) u_grf (
        .clk     (clk),
        .reset   (reset),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .ra0     (rs),
        .ra1     (rt),
        .rd0     (rs_val),
        .rd1     (rt_val)
    );

    assign ext_val  = DW'(ext_imm(imm, ext_op));
    assign b_next   = b_sel ? ext_val : rt_val;
    assign in_ready = !flush && (!valid_reg || out_ready);
    assign load     = in_valid && in_ready;

    // Data registers are never cleared outside reset, so consumers see stable
    // values even while out_valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            a_reg     <= rs_val;
            b_reg     <= b_next;
            op_reg    <= alu_op_in;
        end else if (valid_reg && out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_valid = valid_reg;
    assign A         = a_reg;
    assign B         = b_reg;
    assign ALUOp     = op_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed test-plan steps followed by random traffic, each cycle checked
// against a register-array/held-entry reference model.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [1:0]  ext_op;
    logic        b_sel;
    logic [2:0]  alu_op_in;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALUOp;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [2:0]  m_op;

    logic [31:0] save_a;
    logic [31:0] save_b;
    logic [2:0]  save_op;

    always #5 clk = ~clk;

    operand_fetch #(.DW(32), .AW(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs        (rs),
        .rt        (rt),
        .imm       (imm),
        .ext_op    (ext_op),
        .b_sel     (b_sel),
        .alu_op_in (alu_op_in),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A         (A),
        .B         (B),
        .ALUOp     (ALUOp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] m_ext();
        if (ext_op == 2'b01) return {{16{imm[15]}}, imm};
        if (ext_op == 2'b10) return {imm, 16'h0000};
        return {16'h0000, imm};
    endfunction

    task automatic idle();
        reset = 0; in_valid = 0; rs = 0; rt = 0; imm = 0; ext_op = 0; b_sel = 0;
        alu_op_in = 0; wb_en = 0; wb_addr = 0; wb_data = 0; flush = 0; out_ready = 1;
    endtask

    // Called just after an edge with new inputs applied: checks in_ready,
    // advances the model across the next edge, then checks the outputs.
    task automatic cycle();
        logic exp_ready;
        #1;
        exp_ready = !flush && (!m_valid || out_ready);
        if (!reset) check("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
        if (reset) begin
            m_valid = 0; m_a = 0; m_b = 0; m_op = 0;
            for (int i = 0; i < 32; i++) m_regs[i] = 0;
        end else begin
            if (flush) begin
                m_valid = 0;
            end else if (in_valid && exp_ready) begin
                m_a = m_read(rs);
                m_b = b_sel ? m_ext() : m_read(rt);
                m_op = alu_op_in;
                m_valid = 1;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
            if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
        end
        @(posedge clk);
        #1;
        check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        check("A", A, m_a);
        check("B", B, m_b);
        check("ALUOp", {29'b0, ALUOp}, {29'b0, m_op});
    endtask

    initial begin
        m_valid = 0; m_a = 0; m_b = 0; m_op = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        idle();

        // Reset, then read an unwritten register.
        reset = 1; cycle(); cycle();
        idle(); cycle();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1; rs = 5; cycle();
        check("rs5_A", A, 32'h0);

        // Write r3, load it next cycle with a sign-extended immediate.
        idle(); wb_en = 1; wb_addr = 3; wb_data = 32'h12345678; cycle();
        idle(); in_valid = 1; rs = 3; b_sel = 1; ext_op = 2'b01; imm = 16'hFFFE; cycle();
        check("r3_A", A, 32'h12345678);
        check("sext_B", B, 32'hFFFFFFFE);
        check("r3_valid", {31'b0, out_valid}, 32'd1);

        // Same-cycle bypass on rt.
        idle(); in_valid = 1; rt = 7; wb_en = 1; wb_addr = 7; wb_data = 32'hA5A5A5A5; cycle();
        check("bypass_B", B, 32'hA5A5A5A5);

        // Writes to r0 are ignored.
        idle(); wb_en = 1; wb_addr = 0; wb_data = 32'hFFFFFFFF; cycle();
        idle(); in_valid = 1; rs = 0; cycle();
        check("r0_A", A, 32'h0);

        // Stall three cycles, then release: next entry with no bubble.
        save_a = A; save_b = B; save_op = ALUOp;
        idle(); in_valid = 1; rs = 3; alu_op_in = 3'b011; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_ready", {31'b0, in_ready}, 32'd0);
            check("stall_A", A, save_a);
            check("stall_B", B, save_b);
            check("stall_op", {29'b0, ALUOp}, {29'b0, save_op});
        end
        out_ready = 1; cycle();
        check("release_A", A, 32'h12345678);
        check("release_op", {29'b0, ALUOp}, 32'd3);
        check("release_valid", {31'b0, out_valid}, 32'd1);
        idle(); cycle();
        check("no_dup_valid", {31'b0, out_valid}, 32'd0);

        // Flush with a held entry; write-back in the flush cycle still lands.
        idle(); in_valid = 1; rs = 7; cycle();
        idle(); in_valid = 1; flush = 1; out_ready = 0; wb_en = 1; wb_addr = 9; wb_data = 32'hCAFEF00D;
        #1;
        check("flush_in_ready", {31'b0, in_ready}, 32'd0);
        cycle();
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        idle(); in_valid = 1; rs = 9; cycle();
        check("flush_wb_A", A, 32'hCAFEF00D);

        // Immediate forms and opcode pass-through.
        idle(); in_valid = 1; b_sel = 1; ext_op = 2'b10; imm = 16'h1234; alu_op_in = 3'b101; cycle();
        check("lui_B", B, 32'h12340000);
        check("sra_op", {29'b0, ALUOp}, 32'd5);
        ext_op = 2'b00; imm = 16'h8000; cycle();
        check("zext_B", B, 32'h00008000);
        ext_op = 2'b11; cycle();
        check("rsvd_B", B, 32'h00008000);

        // Reset during a stall drops the entry.
        idle(); in_valid = 1; cycle();
        out_ready = 0; in_valid = 0; cycle();
        reset = 1; cycle();
        idle(); #1;
        check("rst_stall_ready", {31'b0, in_ready}, 32'd1);
        check("rst_stall_valid", {31'b0, out_valid}, 32'd0);
        cycle();

        // Random traffic; narrow address range to exercise bypass often.
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 79) == 0);
            in_valid  = $urandom_range(0, 3) != 0;
            rs        = 5'($urandom_range(0, 7));
            rt        = 5'($urandom_range(0, 7));
            imm       = 16'($urandom);
            ext_op    = 2'($urandom);
            b_sel     = 1'($urandom);
            alu_op_in = 3'($urandom);
            wb_en     = 1'($urandom);
            wb_addr   = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            flush     = ($urandom_range(0, 9) == 0);
            out_ready = $urandom_range(0, 9) < 7;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
